shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
Parametrised, pipelined barrel shifter that replaces the 16-bit combinational shifter in the ALU datapath. It supports four shift types (LSL, LSR, ASR, ROR) and produces carry and zero flags. Operations flow through log2(WIDTH) registered stages under a valid/ready handshake with back-pressure. One operation is accepted per cycle when the pipe is not stalled.

Parameters:
- WIDTH, 16, data width in bits; power of two, 4..64.
- AMT_W, $clog2(WIDTH), shift-amount width and pipeline depth. Derived; must not be overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operation present on the input bus.
- in_ready, output, 1, pipe can accept an operation this cycle.
- in_data, input, WIDTH, operand.
- in_amount, input, AMT_W, shift amount 0..WIDTH-1.
- in_type, input, 2, shift type: 0 LSL, 1 LSR, 2 ASR, 3 ROR.
- in_carry, input, 1, incoming carry flag; passed through when amount is 0.
- out_valid, output, 1, result present on the output bus.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, WIDTH, shifted result.
- out_carry, output, 1, carry flag.
- out_zero, output, 1, high when out_data is 0.

Behaviour:
- Reset: on any clk edge with rst_n=0, all stage valid bits, out_valid, out_data, out_carry and out_zero clear to 0. All in-flight operations are discarded, including during a stall. in_ready=1 from the first cycle after reset.
- Pipeline structure:
  - AMT_W stages, each with a register.
  - Stage k conditionally shifts by 2^k according to amount bit k. LSB-first order is required.
  - Each stage carries its own valid, type, remaining amount bits and carry.
- Latency: an operation accepted at edge N appears on out_* after edge N+AMT_W−1 (visible in cycle N+AMT_W−1..N+AMT_W). For WIDTH=16, latency is 4 cycles.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall, combinational.
  - On stall, every stage holds, bubbles included. There is no bubble collapsing.
  - Without stall, all stages advance every cycle. An empty slot enters as valid=0.
  - out_* are stable while out_valid && !out_ready.
- Arithmetic, for n = amount, d = in_data, W = WIDTH:
  - LSL: out = d << n, zero-fill. Carry = d[W−n] for n>0.
  - LSR: out = d >> n, zero-fill. Carry = d[n−1] for n>0.
  - ASR: out = d >>> n, sign-fill from d[W−1]. Carry = d[n−1] for n>0.
  - ROR: out = (d >> n) | (d << (W−n)). Carry = d[n−1] (= out[W−1]) for n>0.
  - n=0, all types: out = d, carry = in_carry.
  - out_zero = (out_data == 0), registered together with out_data.
- Boundaries:
  - n = W−1 is the maximum amount. ASR by W−1 yields all-sign.
  - ROR by any n is lossless.
  - Back-to-back operations with different types and amounts do not interfere. Each stage uses only its own captured type and amount.
  - in_valid asserted during reset is ignored.
  - If in_valid drops while the pipe is stalled, nothing is lost, because in_ready=0 so nothing was accepted.
- No state machine beyond the per-stage valid bits. Results are strictly in order.

Test Plan:
- WIDTH=16, in_data=0xF0C8, amount=3, in_carry=0, out_ready=1, types 0..3 issued back-to-back:
  - Type 0 (LSL) → out_data=0x8640, c=1.
  - Type 1 (LSR) → 0x1E19, c=0.
  - Type 2 (ASR) → 0xFE19, c=0.
  - Type 3 (ROR) → 0x1E19, c=0.
  - Results arrive on four consecutive cycles, each 4 cycles after its issue.
- Carry and zero edge cases:
  - amount=0, in_carry=1, data 0x1234, each type → out_data=0x1234, c=1, zero=0.
  - ROR 0x0001 by 1 → 0x8000, c=1.
  - LSR 0x0001 by 1 → 0x0000, c=1, zero=1.
- Maximum amount:
  - ASR 0x8000 by 15 → 0xFFFF, c=0.
  - LSL 0x0001 by 15 → 0x8000, c=0.
- Back-pressure:
  - Stimulus: six operations on consecutive cycles, out_ready held low for 3 cycles once the first result is valid.
  - Response: in_ready=0 exactly while stalled. The head result is held stable. All six results emerge in order with no loss or duplication.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge with two operations in flight.
  - Response: out_valid=0 and out_data=0 next cycle. No stale result appears afterward, and in_ready=1.
- Generic width:
  - WIDTH=32, ROR 0x80000001 by 31 → 0x00000003, c=0, latency 5 cycles.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry and zero flags.
// One log2(WIDTH) stage per amount bit, LSB first, under valid/ready back-pressure.
module shifter_pipe #(
  parameter int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [1:0]       in_type,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
  } step_t;

  // One conditional shift by s; carry is the last bit shifted out, else passed through.
  function automatic step_t shift_step(input logic [WIDTH-1:0] v,
                                       input logic [1:0]       typ,
                                       input logic             en,
                                       input logic             cin,
                                       input int               s);
    logic signed [WIDTH-1:0] sv;
    logic        [WIDTH-1:0] tmp;
    step_t                   r;
    sv      = $signed(v);
    r.data  = v;
    r.carry = cin;
    if (en) begin
      case (typ)
        2'd0: begin
          r.data  = v << s;
          tmp     = v >> (WIDTH - s);
          r.carry = tmp[0];
        end
        2'd1: begin
          r.data  = v >> s;
          tmp     = v >> (s - 1);
          r.carry = tmp[0];
        end
        2'd2: begin
          r.data  = sv >>> s;
          tmp     = v >> (s - 1);
          r.carry = tmp[0];
        end
        default: begin
          r.data  = (v >> s) | (v << (WIDTH - s));
          tmp     = v >> (s - 1);
          r.carry = tmp[0];
        end
      endcase
    end
    return r;
  endfunction

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stages 0..AMT_W-2: each consumes amount bit 0 of its source and forwards the rest.
  for (genvar k = 0; k < AMT_W - 1; k++) begin : g_stage
    localparam int RW = AMT_W - 1 - k;

    logic             src_vld;
    logic [WIDTH-1:0] src_data;
    logic [1:0]       src_type;
    logic [RW:0]      src_amt;
    logic             src_carry;

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       type_q;
    logic [RW-1:0]    amt_q;
    logic             carry_q;
    step_t            nxt;

    if (k == 0) begin : g_src
      assign src_vld   = in_valid && in_ready;
      assign src_data  = in_data;
      assign src_type  = in_type;
      assign src_amt   = in_amount;
      assign src_carry = in_carry;
    end else begin : g_src
      assign src_vld   = g_stage[k-1].vld_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_type  = g_stage[k-1].type_q;
      assign src_amt   = g_stage[k-1].amt_q;
      assign src_carry = g_stage[k-1].carry_q;
    end

    assign nxt = shift_step(src_data, src_type, src_amt[0], src_carry, 1 << k);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (!stall) begin
        vld_q <= src_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        data_q  <= nxt.data;
        carry_q <= nxt.carry;
        type_q  <= src_type;
        amt_q   <= src_amt[RW:1];
      end
    end
  end

  // Final stage: shift by 2^(AMT_W-1) straight into the output registers.
  localparam int L = AMT_W - 2;

  step_t fin;

  assign fin = shift_step(g_stage[L].data_q, g_stage[L].type_q, g_stage[L].amt_q[0],
                          g_stage[L].carry_q, 1 << (AMT_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!stall) begin
      out_valid <= g_stage[L].vld_q;
      out_data  <= fin.data;
      out_carry <= fin.carry;
      out_zero  <= (fin.data == '0);
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: scoreboard of expected results (16-bit instance) plus
// a directed check on a 32-bit instance.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_carry;
  logic [15:0] in_data;
  logic [3:0]  in_amount;
  logic [1:0]  in_type;
  logic        out_valid, out_ready, out_carry, out_zero;
  logic [15:0] out_data;

  logic        v2, r2, c2, ov2, or2, oc2, oz2;
  logic [31:0] d2, od2;
  logic [4:0]  a2;
  logic [1:0]  t2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        chk_e;
  bit          bp_seen;
  logic [15:0] bp_held;

  shifter_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_type(in_type), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero)
  );

  shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(r2), .in_data(d2),
    .in_amount(a2), .in_type(t2), .in_carry(c2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .out_carry(oc2), .out_zero(oz2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got %h required %h", name, obs, exp);
    end
  endtask

  // Direct reference model of the four shift types for 16-bit operands.
  function automatic void model(input logic [15:0] d, input int n, input logic [1:0] t,
                                input logic cin, output logic [15:0] o, output logic c);
    logic [15:0] fill;
    o = d;
    c = cin;
    if (n != 0) begin
      case (t)
        2'd0: begin o = d << n; c = d[16-n]; end
        2'd1: begin o = d >> n; c = d[n-1]; end
        2'd2: begin
          fill = ~(16'hFFFF >> n);
          o    = (d >> n) | (d[15] ? fill : 16'h0000);
          c    = d[n-1];
        end
        default: begin o = (d >> n) | (d << (16 - n)); c = d[n-1]; end
      endcase
    end
  endfunction

  // Scoreboard pop: a result transfers at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_result got %h required none", out_data);
      end
      if (sb.size() != 0) begin
        chk_e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(chk_e.d));
        chk("out_carry", 64'(out_carry), 64'(chk_e.c));
        chk("out_zero", 64'(out_zero), 64'(chk_e.d == 16'h0000));
        if (chk_e.lat) chk("latency", 64'(cyc - chk_e.acc), 64'd3);
      end
    end
  end

  // Drive one operation (called just after a rising edge); returns after it is accepted.
  task automatic issue_core(input logic [15:0] d, input int n, input logic [1:0] t,
                            input logic c, input bit use_exp, input logic [15:0] ed,
                            input logic ec, input bit lat);
    logic [15:0] md;
    logic        mc;
    bit          acc;
    exp_t        e;
    if (use_exp) begin
      md = ed;
      mc = ec;
    end else begin
      model(d, n, t, c, md, mc);
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = 4'(n);
    in_type   = t;
    in_carry  = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      if (acc) begin
        e.d   = md;
        e.c   = mc;
        e.acc = cyc + 1;
        e.lat = lat;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (acc) return;
    end
    n_chk++;
    n_fail++;
    $error("FAIL issue_timeout got in_ready=0 required 1");
  endtask

  task automatic issue_x(input logic [15:0] d, input int n, input logic [1:0] t,
                         input logic c, input logic [15:0] ed, input logic ec);
    issue_core(d, n, t, c, 1'b1, ed, ec, 1'b1);
  endtask

  task automatic issue_m(input logic [15:0] d, input int n, input logic [1:0] t,
                         input logic c, input bit lat);
    issue_core(d, n, t, c, 1'b0, 16'h0, 1'b0, lat);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; in_amount = 4'd5;
    in_type = 2'd1; in_carry = 1'b1; out_ready = 1'b1;
    v2 = 1'b0; d2 = '0; a2 = '0; t2 = '0; c2 = 1'b0; or2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    idle(6);

    // Four types back-to-back on the same operand
    issue_x(16'hF0C8, 3, 2'd0, 1'b0, 16'h8640, 1'b1);
    issue_x(16'hF0C8, 3, 2'd1, 1'b0, 16'h1E19, 1'b0);
    issue_x(16'hF0C8, 3, 2'd2, 1'b0, 16'hFE19, 1'b0);
    issue_x(16'hF0C8, 3, 2'd3, 1'b0, 16'h1E19, 1'b0);
    idle(8);

    // Zero amount passes carry; single-bit and maximum-amount corners
    for (int t = 0; t < 4; t++) issue_x(16'h1234, 0, 2'(t), 1'b1, 16'h1234, 1'b1);
    issue_x(16'h0001, 1, 2'd3, 1'b0, 16'h8000, 1'b1);
    issue_x(16'h0001, 1, 2'd1, 1'b0, 16'h0000, 1'b1);
    issue_x(16'h8000, 15, 2'd2, 1'b1, 16'hFFFF, 1'b0);
    issue_x(16'h0001, 15, 2'd0, 1'b1, 16'h8000, 1'b0);
    idle(8);

    // Back-pressure: six ops, consumer stalls 3 cycles once the first result shows
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue_m(16'h1111 * 16'(i + 1) ^ 16'h8421, i * 3 % 16, 2'(i), 1'(i), 1'b0);
        in_valid = 1'b0;
      end
      begin
        bp_seen = 1'b0;
        for (int i = 0; i < 30 && !bp_seen; i++) begin
          @(posedge clk);
          #1;
          bp_seen = (out_valid === 1'b1);
        end
        chk("bp_first_valid", 64'(bp_seen), 64'd1);
        if (bp_seen) begin
          out_ready = 1'b0;
          bp_held   = out_data;
          repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_head_stable", 64'(out_data), 64'(bp_held));
          end
          @(posedge clk);
          #1;
          out_ready = 1'b1;
          @(negedge clk);
          chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        end
      end
    join
    idle(12);

    for (int i = 0; i < 24; i++)
      issue_m(16'($urandom), int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1);
    idle(10);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Reset with two operations in flight and in_valid held high
    issue_m(16'hAAAA, 1, 2'd0, 1'b0, 1'b0);
    issue_m(16'h5555, 2, 2'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    idle(10);
    chk("midrst_no_stale", 64'(sb.size()), 64'd0);

    // 32-bit instance: ROR by 31, five-stage pipe
    v2 = 1'b1; d2 = 32'h8000_0001; a2 = 5'd31; t2 = 2'd3; c2 = 1'b0;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w32_not_early", 64'(ov2), 64'd0);
    @(posedge clk);
    #1;
    chk("w32_valid", 64'(ov2), 64'd1);
    chk("w32_data", 64'(od2), 64'h0000_0003);
    chk("w32_carry", 64'(oc2), 64'd0);
    chk("w32_zero", 64'(oz2), 64'd0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
